// File: rtl/cmult_arbiter_pkg.sv
// Shared types and constants for the cmult_arbiter slice: requester tag type,
// result record carried through the result FIFO, and the fixed multiplier latency.
package cmult_arbiter_pkg;

    localparam int ARB_NREQ      = 4;
    localparam int ARB_PWIDTH    = 16;
    localparam int CMULT_LATENCY = 7;
    localparam int ID_W          = $clog2(ARB_NREQ);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        id_t                   id;
        logic [ARB_PWIDTH-1:0] pr;
        logic [ARB_PWIDTH-1:0] pi;
        logic                  ovf;
    } result_t;

    // Requester index 'off' positions after 'base', wrapping at nreq.
    function automatic id_t rr_offset(input id_t base, input int off, input int nreq);
        return id_t'((int'(base) + off) % nreq);
    endfunction

endpackage

// File: rtl/cmult.sv
// Pipelined complex multiplier, 7 clocks input to output.
// p = round_half_up((a*b) >> SRABITS) truncated to PWIDTH; ovf flags a product whose
// discarded upper bits do not all match the kept sign bit (real or imaginary).
module cmult #(
    parameter int AWIDTH  = 16,
    parameter int BWIDTH  = 16,
    parameter int PWIDTH  = 16,
    parameter int SRABITS = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    output logic signed [PWIDTH-1:0] pr,
    output logic signed [PWIDTH-1:0] pi,
    output logic                     ovf
);

    localparam int MW   = AWIDTH + BWIDTH;
    localparam int SW   = MW + 1;
    localparam int RW   = SW + 1;
    localparam int TAIL = 3;
    localparam logic signed [RW-1:0] RND = {{(RW-SRABITS){1'b0}}, 1'b1, {(SRABITS-1){1'b0}}};

    // True when the bits above the kept sign bit disagree with it.
    function automatic logic hi_mismatch(input logic [RW-1:0] v);
        logic [RW-PWIDTH:0] hi;
        hi = v[RW-1:PWIDTH-1];
        return !((&hi) || !(|hi));
    endfunction

    logic signed [AWIDTH-1:0] ar1_r, ai1_r;
    logic signed [BWIDTH-1:0] br1_r, bi1_r;
    logic signed [MW-1:0]     mrr2_r, mii2_r, mri2_r, mir2_r;
    logic signed [SW-1:0]     sr3_r, si3_r;
    logic signed [RW-1:0]     rsum_s, isum_s, rsh_s, ish_s;
    logic                     ovf_rnd_s;
    logic [PWIDTH-1:0]        pr_d_r [TAIL+1];
    logic [PWIDTH-1:0]        pi_d_r [TAIL+1];
    logic                     ovf_d_r [TAIL+1];

    // Round half up, arithmetic shift and overflow detection on the summed products.
    always_comb begin
        rsum_s    = RW'(sr3_r) + RND;
        isum_s    = RW'(si3_r) + RND;
        rsh_s     = rsum_s >>> SRABITS;
        ish_s     = isum_s >>> SRABITS;
        ovf_rnd_s = hi_mismatch(rsh_s) | hi_mismatch(ish_s);
    end

    // Seven register stages: operands, partial products, sums, rounded result, three delay stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar1_r  <= '0;
            ai1_r  <= '0;
            br1_r  <= '0;
            bi1_r  <= '0;
            mrr2_r <= '0;
            mii2_r <= '0;
            mri2_r <= '0;
            mir2_r <= '0;
            sr3_r  <= '0;
            si3_r  <= '0;
            for (int i = 0; i <= TAIL; i++) begin
                pr_d_r[i]  <= '0;
                pi_d_r[i]  <= '0;
                ovf_d_r[i] <= 1'b0;
            end
        end else begin
            ar1_r  <= ar;
            ai1_r  <= ai;
            br1_r  <= br;
            bi1_r  <= bi;
            mrr2_r <= MW'(ar1_r) * MW'(br1_r);
            mii2_r <= MW'(ai1_r) * MW'(bi1_r);
            mri2_r <= MW'(ar1_r) * MW'(bi1_r);
            mir2_r <= MW'(ai1_r) * MW'(br1_r);
            sr3_r  <= SW'(mrr2_r) - SW'(mii2_r);
            si3_r  <= SW'(mri2_r) + SW'(mir2_r);
            pr_d_r[0]  <= rsh_s[PWIDTH-1:0];
            pi_d_r[0]  <= ish_s[PWIDTH-1:0];
            ovf_d_r[0] <= ovf_rnd_s;
            for (int i = 1; i <= TAIL; i++) begin
                pr_d_r[i]  <= pr_d_r[i-1];
                pi_d_r[i]  <= pi_d_r[i-1];
                ovf_d_r[i] <= ovf_d_r[i-1];
            end
        end
    end

    assign pr  = pr_d_r[TAIL];
    assign pi  = pi_d_r[TAIL];
    assign ovf = ovf_d_r[TAIL];

endmodule

// File: rtl/cmult_arbiter_chk.sv
// Invariant checker for the credit scheme: the FIFO is never pushed while full and
// the credit counter never leaves the range 0..FIFO_DEPTH.
module cmult_arbiter_chk #(
    parameter int FIFO_DEPTH = 8,
    parameter int CRED_W     = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              push,
    input logic              full,
    input logic              issue,
    input logic              pop,
    input logic [CRED_W-1:0] credits
);

    // Sample the invariants on every active edge outside reset.
    always @(posedge clk) begin
        if (rst_n) begin
            a_no_push_full: assert (!(push && full));
            a_cred_range:   assert (credits <= CRED_W'(FIFO_DEPTH));
            a_cred_under:   assert (!(issue && (credits == '0)));
            a_cred_over:    assert (!(pop && !issue && (credits == CRED_W'(FIFO_DEPTH))));
        end
    end

endmodule

// File: rtl/cmult_arbiter_fifo.sv
// First-word-fall-through result FIFO. The head entry is presented whenever valid is
// high and stays put until popped. valid/full are registered occupancy flags.
module cmult_arbiter_fifo
    import cmult_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  result_t din,
    input  logic    pop,
    output result_t dout,
    output logic    valid,
    output logic    full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    result_t         mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic            pop_ok_s;

    // Next occupancy from this cycle's push and (qualified) pop.
    always_comb begin
        pop_ok_s = pop && valid;
        case ({push, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array and read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy counter and the registered empty/full flags derived from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            valid   <= 1'b0;
            full    <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            valid   <= (count_nxt_s != '0);
            full    <= (count_nxt_s == CW'(DEPTH));
        end
    end

    assign dout = mem_r[rd_ptr_r];

endmodule

// File: rtl/cmult_arbiter.sv
// Shares one cmult between NREQ requesters. A round-robin arbiter issues at most one
// operand pair per clock while credits remain; a {valid,id} tag pipe follows each product
// through the multiplier and pushes the tagged result into a FWFT FIFO. Credits track free
// FIFO slots minus products still in the multiplier, so the FIFO can never overflow.
module cmult_arbiter
    import cmult_arbiter_pkg::*;
#(
    parameter int NREQ       = ARB_NREQ,
    parameter int AWIDTH     = 16,
    parameter int BWIDTH     = 16,
    parameter int PWIDTH     = ARB_PWIDTH,
    parameter int SRABITS    = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                s_valid,
    output logic [NREQ-1:0]                s_ready,
    input  logic [NREQ-1:0][AWIDTH-1:0]    s_ar,
    input  logic [NREQ-1:0][AWIDTH-1:0]    s_ai,
    input  logic [NREQ-1:0][BWIDTH-1:0]    s_br,
    input  logic [NREQ-1:0][BWIDTH-1:0]    s_bi,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(NREQ)-1:0]        m_id,
    output logic [PWIDTH-1:0]              m_pr,
    output logic [PWIDTH-1:0]              m_pi,
    output logic                           m_ovf
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    id_t                          ptr_r;
    logic [CRED_W-1:0]            credits_r;
    logic                         found_s;
    id_t                          grant_id_s;
    logic                         issue_s;
    logic                         pop_s;
    logic [AWIDTH-1:0]            op_ar_s, op_ai_s;
    logic [BWIDTH-1:0]            op_br_s, op_bi_s;
    logic [CMULT_LATENCY-1:0]     tag_v_r;
    id_t [CMULT_LATENCY-1:0]      tag_id_r;
    logic [PWIDTH-1:0]            c_pr_s, c_pi_s;
    logic                         c_ovf_s;
    logic                         push_s;
    logic                         fifo_full_s;
    result_t                      fifo_din_s;
    result_t                      fifo_dout_s;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        found_s    = 1'b0;
        grant_id_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && s_valid[rr_offset(ptr_r, k, NREQ)]) begin
                found_s    = 1'b1;
                grant_id_s = rr_offset(ptr_r, k, NREQ);
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Issue only with a free credit; steer the winner's operands to the multiplier, zeros when idle.
    always_comb begin
        issue_s = found_s && (credits_r != '0) && rst_n;
        s_ready = '0;
        op_ar_s = '0;
        op_ai_s = '0;
        op_br_s = '0;
        op_bi_s = '0;
        if (issue_s) begin
            s_ready[grant_id_s] = 1'b1;
            op_ar_s = s_ar[grant_id_s];
            op_ai_s = s_ai[grant_id_s];
            op_br_s = s_br[grant_id_s];
            op_bi_s = s_bi[grant_id_s];
        end else begin
            s_ready = '0;
        end
    end

    assign pop_s  = m_valid && m_ready;
    assign push_s = tag_v_r[CMULT_LATENCY-1];

    // Round-robin pointer moves just past the requester that transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (issue_s) begin
            ptr_r <= rr_offset(grant_id_s, 1, NREQ);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Credits: spent on issue, returned on pop, unchanged when both happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_r <= CRED_W'(FIFO_DEPTH);
        end else begin
            case ({issue_s, pop_s})
                2'b10:   credits_r <= credits_r - CRED_W'(1);
                2'b01:   credits_r <= credits_r + CRED_W'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Tag pipe aligned with the multiplier; reset drops every in-flight product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r  <= '0;
            tag_id_r <= '0;
        end else begin
            tag_v_r  <= {tag_v_r[CMULT_LATENCY-2:0], issue_s};
            tag_id_r <= {tag_id_r[CMULT_LATENCY-2:0], grant_id_s};
        end
    end

    cmult #(
        .AWIDTH  (AWIDTH),
        .BWIDTH  (BWIDTH),
        .PWIDTH  (PWIDTH),
        .SRABITS (SRABITS)
    ) u_cmult (
        .clk   (clk),
        .rst_n (rst_n),
        .ar    (op_ar_s),
        .ai    (op_ai_s),
        .br    (op_br_s),
        .bi    (op_bi_s),
        .pr    (c_pr_s),
        .pi    (c_pi_s),
        .ovf   (c_ovf_s)
    );

    assign fifo_din_s = '{id: tag_id_r[CMULT_LATENCY-1], pr: c_pr_s, pi: c_pi_s, ovf: c_ovf_s};

    cmult_arbiter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .valid (m_valid),
        .full  (fifo_full_s)
    );

    assign m_id  = fifo_dout_s.id;
    assign m_pr  = fifo_dout_s.pr;
    assign m_pi  = fifo_dout_s.pi;
    assign m_ovf = fifo_dout_s.ovf;

    cmult_arbiter_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CRED_W     (CRED_W)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .full    (fifo_full_s),
        .issue   (issue_s),
        .pop     (pop_s),
        .credits (credits_r)
    );

endmodule

// File: tb/tb_cmult_arbiter.sv
// Bench for cmult_arbiter: a queue-based reference model (outstanding products with their
// due cycle) is checked on every falling edge, plus directed literal checks.
module tb_cmult_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       s_valid;
    logic [NREQ-1:0]       s_ready;
    logic [NREQ-1:0][15:0] s_ar, s_ai, s_br, s_bi;
    logic                  m_valid;
    logic                  m_ready;
    logic [1:0]            m_id;
    logic [15:0]           m_pr, m_pi;
    logic                  m_ovf;

    cmult_arbiter dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_ar(s_ar), .s_ai(s_ai), .s_br(s_br), .s_bi(s_bi),
        .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id),
        .m_pr(m_pr), .m_pi(m_pi), .m_ovf(m_ovf)
    );

    always #5 clk = ~clk;

    typedef struct { int rdy; int id; int pr; int pi; int ovf; } exp_t;

    exp_t q[$];
    int   glog[$];
    int   total = 0, bad = 0, cyc = 0;
    int   m_ptr = 0, n_grant = 0, n_pop = 0, n_mv = 0;
    int   g, gi;
    bit   mv_exp;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Round half up by 2^15, then wrap to 16 bits; overflow when wrapping changed the value.
    function automatic void ref_part(input longint full, output int p, output int o);
        longint t, w;
        t = (full + 64'sd16384) >>> 15;
        w = t & 64'sd65535;
        if (w >= 64'sd32768) w = w - 64'sd65536;
        p = int'(w);
        o = (t != w) ? 1 : 0;
    endfunction

    function automatic exp_t ref_mul(input int id, input int ar, input int ai,
                                     input int br, input int bi, input int rdy);
        exp_t e;
        int   orr, oii;
        ref_part(longint'(ar) * br - longint'(ai) * bi, e.pr, orr);
        ref_part(longint'(ar) * bi + longint'(ai) * br, e.pi, oii);
        e.ovf = orr | oii;
        e.id  = id;
        e.rdy = rdy;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_s_ready", s_ready, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_id", m_id, 0);
            check("rst_m_pr", m_pr, 0);
            check("rst_m_pi", m_pi, 0);
            check("rst_m_ovf", m_ovf, 0);
            q.delete();
            m_ptr = 0;
        end else begin
            g = -1;
            if (q.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && s_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            check("s_ready", s_ready, (g >= 0) ? (1 << g) : 0);
            if (s_ready != '0) begin
                n_grant++;
                gi = 0;
                for (int k = 0; k < NREQ; k++) if (s_ready[k]) gi = k;
                glog.push_back(gi);
            end
            mv_exp = (q.size() > 0) && (q[0].rdy <= cyc);
            check("m_valid", m_valid, mv_exp);
            if (m_valid) n_mv++;
            if (mv_exp && m_valid) begin
                check("m_id", m_id, q[0].id);
                check("m_pr", $signed(m_pr), q[0].pr);
                check("m_pi", $signed(m_pi), q[0].pi);
                check("m_ovf", m_ovf, q[0].ovf);
                if (m_ready) begin
                    void'(q.pop_front());
                    n_pop++;
                end
            end
            if (g >= 0) begin
                q.push_back(ref_mul(g, int'($signed(s_ar[g])), int'($signed(s_ai[g])),
                                    int'($signed(s_br[g])), int'($signed(s_bi[g])), cyc + LAT));
                m_ptr = (g + 1) % NREQ;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h8000;
        if (r == 1) return 16'h7FFF;
        return 16'($urandom);
    endfunction

    task automatic rand_operands();
        for (int k = 0; k < NREQ; k++) begin
            s_ar[k] = rand_op(); s_ai[k] = rand_op();
            s_br[k] = rand_op(); s_bi[k] = rand_op();
        end
    endtask

    task automatic drain(input int n);
        s_valid = '0;
        m_ready = 1'b1;
        repeat (n) step();
    endtask

    // Single isolated product: latency and literal result values.
    task automatic one_shot(input string tag, input int id, input int ar, input int ai,
                            input int br, input int bi, input int epr, input int epi, input int eovf);
        int n;
        bit seen;
        step();
        s_valid     = '0;
        s_valid[id] = 1'b1;
        s_ar[id] = 16'(ar); s_ai[id] = 16'(ai); s_br[id] = 16'(br); s_bi[id] = 16'(bi);
        m_ready = 1'b1;
        @(negedge clk);
        check({tag, "_grant"}, s_ready, 1 << id);
        step();
        s_valid = '0;
        seen = 1'b0;
        n = -1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                n = k;
            end
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_id"}, m_id, id);
        check({tag, "_pr"}, $signed(m_pr), epr);
        check({tag, "_pi"}, $signed(m_pi), epi);
        check({tag, "_ovf"}, m_ovf, eovf);
        drain(4);
    endtask

    initial begin
        int n0, p0, mv0;
        rst_n = 1'b0; s_valid = '0; m_ready = 1'b0;
        s_ar = '0; s_ai = '0; s_br = '0; s_bi = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Model pins: 0.5*0.5, overflow on both parts, overflow on imaginary only.
        one_shot("q15_half", 0, 16384, 0, 16384, 0, 8192, 0, 0);
        one_shot("ovf_both", 2, -32768, -32768, -32768, 0, -32768, -32768, 1);
        one_shot("ovf_pi", 3, 16384, -32768, -32768, 0, -16384, -32768, 1);

        // All requesters continuously valid: grants rotate in round-robin order.
        drain(12);
        glog.delete();
        s_valid = '1;
        for (int c = 0; c < 40; c++) begin
            rand_operands();
            step();
        end
        s_valid = '0;
        check("rr_grant_count_min", (glog.size() >= 20) ? 1 : 0, 1);
        for (int k = 1; k < glog.size(); k++) check("rr_order", glog[k], (glog[k-1] + 1) % NREQ);

        // Backpressure: exactly FIFO_DEPTH grants, then stall; drain releases 8 in order.
        drain(16);
        n0 = n_grant;
        m_ready = 1'b0;
        s_valid = '1;
        repeat (20) step();
        check("bp_grants", n_grant - n0, DEPTH);
        @(negedge clk);
        check("bp_ready_zero", s_ready, 0);
        step();
        s_valid = '0;
        m_ready = 1'b1;
        p0 = n_pop;
        repeat (16) step();
        check("bp_drained", n_pop - p0, DEPTH);
        s_valid = '1;
        @(negedge clk);
        check("bp_resume", (s_ready != '0) ? 1 : 0, 1);
        drain(16);

        // Reset with five products in flight: nothing emerges, credits fully restored.
        n0 = n_grant;
        s_valid = '1;
        repeat (5) step();
        check("rst_inflight_grants", n_grant - n0, 5);
        rst_n = 1'b0;
        s_valid = '0;
        repeat (3) step();
        rst_n = 1'b1;
        mv0 = n_mv;
        repeat (20) step();
        check("rst_no_stale", n_mv - mv0, 0);
        n0 = n_grant;
        m_ready = 1'b0;
        s_valid = '1;
        repeat (20) step();
        check("rst_credits_back", n_grant - n0, DEPTH);
        drain(20);

        // Randomised traffic against the model.
        p0 = n_pop;
        for (int c = 0; c < 40000 && (n_pop - p0) < 10000; c++) begin
            step();
            s_valid = ($urandom_range(0, 9) == 0) ? '0 : NREQ'($urandom);
            rand_operands();
            m_ready = ($urandom_range(0, 9) < 7);
        end
        check("rand_txns", ((n_pop - p0) >= 10000) ? 1 : 0, 1);
        drain(20);
        check("no_loss", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
